// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundle of the functional-unit result handshake, the branch
// resolution bus and the common data bus (CDB) seen by cdb_arbiter.
//
// Handshake semantics (valid/ready, one comment for the whole bundle):
//   - An FU raises fu_valid[i] with its payload (fu_data/fu_prd/fu_rob/fu_mask)
//     and holds valid and payload stable until it is accepted.
//   - A transfer happens in a cycle where fu_valid[i] & fu_ready[i] is high.
//     The FU drops (or replaces) its result the next cycle.
//   - fu_ready[i] never rises for an FU whose fu_valid[i] is low, and at most
//     one fu_ready bit is high per cycle.
//   - The CDB has no backpressure: cdb_valid is a one-cycle broadcast.
//
// Modports:
//   slave  : the arbiter (consumes FU results, drives fu_ready and the CDB)
//   master : the FU/branch side (drives results and the branch bus)
interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int DATA_W = 32,
  parameter int PRF_W  = 6,
  parameter int ROB_W  = 5,
  parameter int BR_W   = 4
);
  localparam int TAG_W = (BR_W > 1) ? $clog2(BR_W) : 1;

  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU*DATA_W-1:0] fu_data;
  logic [NUM_FU*PRF_W-1:0]  fu_prd;
  logic [NUM_FU*ROB_W-1:0]  fu_rob;
  logic [NUM_FU*BR_W-1:0]   fu_mask;

  logic                     brb_broadcast;
  logic [TAG_W-1:0]         brb_tag;
  logic                     brb_kill;
  logic                     brb_clean;

  logic                     cdb_valid;
  logic [DATA_W-1:0]        cdb_data;
  logic [PRF_W-1:0]         cdb_prd;
  logic [ROB_W-1:0]         cdb_rob;
  logic [BR_W-1:0]          cdb_mask;

  modport slave (
    input  fu_valid, fu_data, fu_prd, fu_rob, fu_mask,
    input  brb_broadcast, brb_tag, brb_kill, brb_clean,
    output fu_ready,
    output cdb_valid, cdb_data, cdb_prd, cdb_rob, cdb_mask
  );

  modport master (
    output fu_valid, fu_data, fu_prd, fu_rob, fu_mask,
    output brb_broadcast, brb_tag, brb_kill, brb_clean,
    input  fu_ready,
    input  cdb_valid, cdb_data, cdb_prd, cdb_rob, cdb_mask
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter between NUM_FU completed functional units
// driving a registered common data bus. Results carrying the branch tag being
// killed are never granted and never broadcast; a clean clears the tag bit
// from the result masks on their way to the CDB.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : cdb_arbiter_if.slave
//          fu_valid/fu_ready + fu_data/fu_prd/fu_rob/fu_mask  FU results
//          brb_broadcast/brb_tag/brb_kill/brb_clean           branch bus
//          cdb_valid/cdb_data/cdb_prd/cdb_rob/cdb_mask        CDB broadcast
//
// Timing: an FU granted in cycle t appears on the CDB in cycle t+1.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int DATA_W = 32,
  parameter int PRF_W  = 6,
  parameter int ROB_W  = 5,
  parameter int BR_W   = 4
) (
  input logic            clk,
  input logic            rst,
  cdb_arbiter_if.slave   bus
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic              kill_active;
  logic              clean_active;
  logic [BR_W-1:0]   tag_onehot;
  logic [NUM_FU-1:0] elig;

  logic              grant_valid;
  logic [PTR_W-1:0]  grant_idx;
  logic [BR_W-1:0]   grant_mask;

  logic [PTR_W-1:0]  rr_ptr;
  logic              reg_valid;
  logic [DATA_W-1:0] reg_data;
  logic [PRF_W-1:0]  reg_prd;
  logic [ROB_W-1:0]  reg_rob;
  logic [BR_W-1:0]   reg_mask;

  // Kill wins over clean if the branch bus ever carries both.
  assign kill_active  = bus.brb_broadcast & bus.brb_kill;
  assign clean_active = bus.brb_broadcast & bus.brb_clean & ~bus.brb_kill;
  assign tag_onehot   = BR_W'(1) << bus.brb_tag;

  // A requester whose mask holds the tag being killed is about to flush
  // itself, so it must not be granted this cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      elig[i] = bus.fu_valid[i] &
                ~(kill_active & (|(bus.fu_mask[i*BR_W +: BR_W] & tag_onehot)));
    end
  end

  // Round-robin search starting at rr_ptr; the first eligible hit wins.
  always_comb begin
    int               idx_i;
    logic [PTR_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx_i       = 0;
    idx         = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx_i = int'(rr_ptr) + k;
      if (idx_i >= NUM_FU) idx_i = idx_i - NUM_FU;
      idx = PTR_W'(idx_i);
      if (!grant_valid && elig[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
    // No acceptance while in reset: the FU would drop a result that the
    // cleared output register never broadcasts.
    if (rst) grant_valid = 1'b0;
  end

  always_comb begin
    bus.fu_ready = '0;
    if (grant_valid) bus.fu_ready[grant_idx] = 1'b1;
  end

  // Mask of the granted result with a same-cycle clean already applied.
  always_comb begin
    grant_mask = bus.fu_mask[int'(grant_idx)*BR_W +: BR_W];
    if (clean_active) grant_mask = grant_mask & ~tag_onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      reg_valid <= 1'b0;
      reg_data  <= '0;
      reg_prd   <= '0;
      reg_rob   <= '0;
      reg_mask  <= '0;
    end else if (grant_valid) begin
      rr_ptr    <= (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
      reg_valid <= 1'b1;
      reg_data  <= bus.fu_data[int'(grant_idx)*DATA_W +: DATA_W];
      reg_prd   <= bus.fu_prd[int'(grant_idx)*PRF_W +: PRF_W];
      reg_rob   <= bus.fu_rob[int'(grant_idx)*ROB_W +: ROB_W];
      reg_mask  <= grant_mask;
    end else begin
      reg_valid <= 1'b0;
      // Held entry still tracks cleans so its mask stays accurate.
      if (clean_active) reg_mask <= reg_mask & ~tag_onehot;
    end
  end

  // A kill hitting the registered entry suppresses the broadcast in the
  // same cycle; the register itself is overwritten/cleared next cycle.
  assign bus.cdb_valid = reg_valid & ~(kill_active & (|(reg_mask & tag_onehot)));
  assign bus.cdb_data  = reg_data;
  assign bus.cdb_prd   = reg_prd;
  assign bus.cdb_rob   = reg_rob;
  assign bus.cdb_mask  = reg_mask;
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int NUM_FU = 4;
  localparam int DATA_W = 32;
  localparam int PRF_W  = 6;
  localparam int ROB_W  = 5;
  localparam int BR_W   = 4;
  localparam int TAG_W  = 2;
  localparam int W      = DATA_W + PRF_W + ROB_W + BR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .PRF_W(PRF_W),
                   .ROB_W(ROB_W), .BR_W(BR_W)) bus();

  cdb_arbiter #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .PRF_W(PRF_W),
                .ROB_W(ROB_W), .BR_W(BR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic         pend  = 1'b0;   // a grant was expected last cycle

  task automatic check_eq(input string tag, input logic [63:0] act,
                          input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fu(input int i, input logic v, input logic [DATA_W-1:0] d,
                        input logic [PRF_W-1:0] p, input logic [ROB_W-1:0] r,
                        input logic [BR_W-1:0] m);
    bus.fu_valid[i]                = v;
    bus.fu_data[i*DATA_W +: DATA_W] = d;
    bus.fu_prd[i*PRF_W +: PRF_W]    = p;
    bus.fu_rob[i*ROB_W +: ROB_W]    = r;
    bus.fu_mask[i*BR_W +: BR_W]     = m;
  endtask

  task automatic set_brb(input logic b, input logic [TAG_W-1:0] t,
                         input logic k, input logic c);
    bus.brb_broadcast = b;
    bus.brb_tag       = t;
    bus.brb_kill      = k;
    bus.brb_clean     = c;
  endtask

  task automatic clear_fus();
    bus.fu_valid = '0;
  endtask

  // One cycle: inputs are already driven (just after posedge). Check at the
  // falling edge, then push the expected CDB entry for this cycle's grant.
  task automatic cycle(input logic [NUM_FU-1:0] exp_ready, input logic exp_kill_out);
    logic [W-1:0]    pkt;
    logic [BR_W-1:0] cm;
    int              g;
    @(negedge clk);
    check_eq("fu_ready", bus.fu_ready, exp_ready);
    if (pend && !exp_kill_out) begin
      check_eq("cdb_valid", bus.cdb_valid, 1);
      pkt = exp_q.pop_front();
      check_eq("cdb_payload", {bus.cdb_data, bus.cdb_prd, bus.cdb_rob, bus.cdb_mask}, pkt);
    end else begin
      check_eq("cdb_valid", bus.cdb_valid, 0);
      if (pend) pkt = exp_q.pop_front();
    end
    pend = (exp_ready != '0);
    if (pend) begin
      g = 0;
      for (int i = 0; i < NUM_FU; i++) if (exp_ready[i]) g = i;
      cm = bus.fu_mask[g*BR_W +: BR_W];
      if (bus.brb_broadcast && bus.brb_clean && !bus.brb_kill) cm[bus.brb_tag] = 1'b0;
      exp_q.push_back({bus.fu_data[g*DATA_W +: DATA_W], bus.fu_prd[g*PRF_W +: PRF_W],
                       bus.fu_rob[g*ROB_W +: ROB_W], cm});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  int              rr_m;
  logic [NUM_FU-1:0] exp_r;
  logic [NUM_FU-1:0] kill_hit;
  logic            b, k, c, ko;
  logic [TAG_W-1:0] t;

  initial begin
    bus.fu_valid = '0;
    bus.fu_data  = '0;
    bus.fu_prd   = '0;
    bus.fu_rob   = '0;
    bus.fu_mask  = '0;
    set_brb(0, 0, 0, 0);
    for (int i = 0; i < NUM_FU; i++)
      set_fu(i, 1'b1, 32'h1000_0000 + i, PRF_W'(10 + i), ROB_W'(20 + i), '0);

    // Reset with every FU requesting: no ready, no CDB.
    @(posedge clk); #1;
    cycle(4'b0000, 0);
    cycle(4'b0000, 0);
    rst = 1'b0;
    cycle(4'b0001, 0);           // FU0 first after release
    clear_fus();
    cycle(4'b0000, 0);           // FU0 on CDB

    // Single request from FU2 (rr_ptr now 1).
    set_fu(2, 1'b1, 32'hDEAD_BEEF, 6'd5, 5'd3, 4'b0000);
    cycle(4'b0100, 0);
    clear_fus();
    cycle(4'b0000, 0);
    cycle(4'b0000, 0);

    // Fairness from a fresh reset: 0,1,2,3,0 with no bubbles.
    rst = 1'b1;
    cycle(4'b0000, 0);
    rst = 1'b0;
    for (int i = 0; i < NUM_FU; i++)
      set_fu(i, 1'b1, 32'hA000_0000 + i, PRF_W'(30 + i), ROB_W'(i), BR_W'(i));
    cycle(4'b0001, 0);
    cycle(4'b0010, 0);
    cycle(4'b0100, 0);
    cycle(4'b1000, 0);
    cycle(4'b0001, 0);
    // Reset asserted while requests are pending: nothing accepted, and the
    // broadcast stops the cycle after reset is seen.
    rst = 1'b1;
    cycle(4'b0000, 0);
    cycle(4'b0000, 0);
    rst = 1'b0;
    clear_fus();

    // Kill on request (clean also raised: kill wins). FU3 granted instead.
    set_fu(1, 1'b1, 32'h1111_1111, 6'd1, 5'd1, 4'b0010);
    set_fu(3, 1'b1, 32'h3333_3333, 6'd3, 5'd7, 4'b0000);
    set_brb(1, 2'd1, 1, 1);
    cycle(4'b1000, 0);
    clear_fus();
    set_brb(0, 0, 0, 0);
    cycle(4'b0000, 0);

    // Kill on the output register (rr_ptr back to 0).
    set_fu(0, 1'b1, 32'h0BAD_F00D, 6'd9, 5'd9, 4'b1000);
    cycle(4'b0001, 0);
    clear_fus();
    set_brb(1, 2'd3, 1, 0);
    cycle(4'b0000, 1);
    set_brb(0, 0, 0, 0);
    cycle(4'b0000, 0);

    // Clean while granting (rr_ptr 1): mask 0110 minus tag 2 -> 0010.
    set_fu(3, 1'b1, 32'hC1EA_0003, 6'd33, 5'd17, 4'b0110);
    set_brb(1, 2'd2, 0, 1);
    cycle(4'b1000, 0);
    clear_fus();
    set_brb(0, 0, 0, 0);
    cycle(4'b0000, 0);

    // Random traffic with kills and cleans; rr_ptr is 0 here.
    rr_m = 0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NUM_FU; i++)
        if (!bus.fu_valid[i] && $urandom_range(0, 1) == 1)
          set_fu(i, 1'b1, $urandom, PRF_W'($urandom), ROB_W'($urandom),
                 BR_W'($urandom_range(0, 15)));
      b = ($urandom_range(0, 3) == 0);
      k = b && ($urandom_range(0, 1) == 1);
      c = b && !k;
      t = TAG_W'($urandom_range(0, 3));
      set_brb(b, t, k, c);
      kill_hit = '0;
      for (int i = 0; i < NUM_FU; i++)
        kill_hit[i] = k && bus.fu_mask[i*BR_W + int'(t)];
      exp_r = '0;
      for (int j = 0; j < NUM_FU; j++) begin
        int idx;
        idx = (rr_m + j) % NUM_FU;
        if (exp_r == '0 && bus.fu_valid[idx] && !kill_hit[idx]) exp_r[idx] = 1'b1;
      end
      ko = 1'b0;
      if (pend && k && exp_q.size() > 0) ko = exp_q[0][int'(t)];
      cycle(exp_r, ko);
      for (int i = 0; i < NUM_FU; i++) begin
        if (exp_r[i]) begin
          bus.fu_valid[i] = 1'b0;
          rr_m = (i + 1) % NUM_FU;
        end
        if (kill_hit[i]) bus.fu_valid[i] = 1'b0;
      end
    end

    clear_fus();
    set_brb(0, 0, 0, 0);
    cycle(4'b0000, 0);
    cycle(4'b0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Consumer end of the functional-unit result handshake (ovalid/oready). Arbitrates among NUM_FU completed FUs (ALU, multiplier, divider, load unit), selects one per cycle and drives a registered common data bus (CDB) to the ROB, reservation stations and PRF.
- Applies EBR branch-bus kill/clean to results in flight so squashed results never broadcast.

Parameters:
- NUM_FU, 4, number of requesting functional units; index 0 = highest initial priority
- DATA_W, 32, result width
- PRF_W, 6, physical destination register index width
- ROB_W, 5, ROB index width
- BR_W, 4, branch mask width (one bit per EBR tag); tag width = $clog2(BR_W)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fu_valid  in  NUM_FU  per-FU result valid (FU ovalid)
- fu_ready  out  NUM_FU  per-FU grant/accept (FU oready)
- fu_data  in  NUM_FU*DATA_W  per-FU result, FU i at slice [i*DATA_W +: DATA_W]
- fu_prd  in  NUM_FU*PRF_W  per-FU physical destination
- fu_rob  in  NUM_FU*ROB_W  per-FU ROB index
- fu_mask  in  NUM_FU*BR_W  per-FU branch mask
- brb_broadcast  in  1  branch resolution valid
- brb_tag  in  $clog2(BR_W)  resolving branch tag
- brb_kill  in  1  mispredict: squash entries with mask[tag] set
- brb_clean  in  1  correct prediction: clear mask[tag]
- cdb_valid  out  1  CDB broadcast valid
- cdb_data  out  DATA_W  broadcast result
- cdb_prd  out  PRF_W  broadcast physical destination
- cdb_rob  out  ROB_W  broadcast ROB index
- cdb_mask  out  BR_W  broadcast branch mask (cleaned)

Behaviour:
- Reset: rr_ptr=0, output register valid=0; data/prd/rob/mask registers=0. cdb_valid=0 and fu_ready=0 in the cycle after reset asserts. Reset mid-transfer drops the pending broadcast.
- Eligibility (comb): elig[i] = fu_valid[i] & ~(brb_broadcast & brb_kill & fu_mask[i][brb_tag]).
- Arbitration: round-robin; search elig starting at rr_ptr, wrapping modulo NUM_FU; first hit = grant index g. At most one grant per cycle.
- fu_ready[i] = 1 only when i==g and elig[i]; all other bits 0. Never asserted to a non-valid FU (FUs clear ovalid on oready; a spurious ready would drop a result).
- Transfer occurs when fu_ready[g]=1; FU deasserts ovalid the next cycle. Zero bubbles: back-to-back grants across FUs every cycle.
- rr_ptr <= (g+1) mod NUM_FU on a grant; unchanged when no eligible requester.
- Latency: grant in cycle t -> cdb_valid=1 with that FU's data/prd/rob in cycle t+1, exactly one cycle. No CDB backpressure.
- Output register loads on grant: data, prd, rob, mask; mask bit brb_tag cleared if brb_broadcast & brb_clean that cycle. No grant -> valid register <= 0.
- Held output mask: if brb_broadcast & brb_clean and register mask[brb_tag]=1, clear that bit (visible next cycle).
- Output kill (comb): cdb_valid = reg_valid & ~(brb_broadcast & brb_kill & reg_mask[brb_tag]). Killed entry never broadcasts; valid register cleared next cycle.
- Kill of a requesting FU: not granted that cycle; FU flushes itself; rr_ptr unchanged unless another FU was granted.
- Simultaneous kill and clean are mutually exclusive on the branch bus; kill takes precedence if both set.
- Ungranted requesters hold fu_valid and payload stable; arbiter samples payload only on grant.

Test Plan:
- Reset: assert rst with fu_valid=4'b1111 -> cdb_valid=0, fu_ready=0 during reset; first cycle after release, fu_ready=4'b0001, CDB shows FU0 at t+1.
- Single request: FU2 valid, data=0xDEADBEEF, prd=5, rob=3 -> fu_ready=4'b0100 same cycle; next cycle cdb_valid=1, cdb_data=0xDEADBEEF, cdb_prd=5, cdb_rob=3; following cycle cdb_valid=0.
- Fairness: all four FUs held valid (re-raising after grant) -> grant order 0,1,2,3,0 on consecutive cycles; CDB valid every cycle, no bubbles.
- Kill on request: FU1 valid, mask=4'b0010; brb_broadcast=1, brb_kill=1, brb_tag=1 same cycle -> fu_ready[1]=0, no broadcast; FU3 valid same cycle is granted instead.
- Kill on output register: FU0 granted with mask=4'b1000; next cycle kill with tag=3 -> cdb_valid=0 that cycle despite registered valid.
- Clean: FU3 granted with mask=4'b0110 while clean tag=2 broadcasts -> cdb_mask=4'b0010 at t+1.
